// File: rtl/acp_pkg.sv
// acp_pkg: shared types and defaults for the ACP/ARP pulse generator.
package acp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } acp_state_t;

    localparam int unsigned ACP_DEFAULT_CLK_HZ = 100000000;
    localparam int unsigned ACP_DEFAULT_PERIOD = 146484;

endpackage : acp_pkg

// File: rtl/acp_period_counter.sv
// acp_period_counter: latched effective period plus a free-running cycle counter
// that flags the last cycle of the pulse and the last cycle of the period.
module acp_period_counter #(
    parameter int unsigned PERIOD_W     = 32,
    parameter int unsigned PULSE_CYCLES = 50
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_load,
    input  logic                i_clear,
    input  logic                i_run,
    input  logic [PERIOD_W-1:0] i_period,
    output logic                o_terminal_c,
    output logic                o_pulse_end_c
);

    // Shortest legal period keeps the duty cycle at or below 50 %.
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2 * PULSE_CYCLES);
    localparam logic [PERIOD_W-1:0] PULSE_LAST = PERIOD_W'(PULSE_CYCLES - 1);

    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] w_eff_period;

    assign w_eff_period = (i_period < MIN_PERIOD) ? MIN_PERIOD : i_period;

    // Period register loads on request; counter clears on pulse start, else counts while running.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_period <= '0;
            r_cnt    <= '0;
        end else begin
            if (i_load) begin
                r_period <= w_eff_period;
            end
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_run) begin
                r_cnt <= r_cnt + PERIOD_W'(1);
            end
        end
    end

    assign o_terminal_c  = (r_cnt == (r_period - PERIOD_W'(1)));
    assign o_pulse_end_c = (r_cnt == PULSE_LAST);

endmodule : acp_period_counter

// File: rtl/acp_arp_generator.sv
// acp_arp_generator: ACP pulse train with run-time period, azimuth index and
// optional once-per-revolution ARP. Define ACP_ARP_EN to build in the ARP output
// and per-revolution period reload; otherwise ARP is tied low and the period is
// only taken when the generator starts from idle.
module acp_arp_generator #(
    parameter int unsigned ACP_PER_REV  = 4096,
    parameter int unsigned PULSE_CYCLES = 50,
    parameter int unsigned PERIOD_W     = 32,
    parameter int unsigned AZ_W         = $clog2(ACP_PER_REV)
) (
    input  logic                IN_CLK,
    input  logic                IN_RST,
    input  logic                EN,
    input  logic [PERIOD_W-1:0] ACP_PERIOD,
    output logic                RADAR_ACP,
    output logic                RADAR_ARP,
    output logic [AZ_W-1:0]     AZIMUTH,
    output logic                RUNNING
);

    import acp_pkg::*;

    acp_state_t      r_state;
    logic            r_en;
    logic            r_acp;
    logic            r_running;
    logic [AZ_W-1:0] r_az;
    logic [AZ_W-1:0] w_az_inc;

    logic w_load;
    logic w_clear;
    logic w_run;
    logic w_terminal;
    logic w_pulse_end;

    assign w_az_inc = r_az + AZ_W'(1);

`ifdef ACP_ARP_EN
    logic r_arp;
    logic w_wrap;

    assign w_wrap = (w_az_inc == '0);
`endif

    // Counter control: clear on every pulse start or stop, load period on start and on revolution wrap.
    always_comb begin
        w_clear = 1'b0;
        w_load  = 1'b0;
        w_run   = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                w_clear = r_en;
                w_load  = r_en;
            end
            LOW: begin
                w_clear = w_terminal;
`ifdef ACP_ARP_EN
                w_load  = w_terminal & r_en & w_wrap;
`endif
            end
            default: begin
                w_clear = 1'b0;
            end
        endcase
    end

    acp_period_counter #(
        .PERIOD_W     (PERIOD_W),
        .PULSE_CYCLES (PULSE_CYCLES)
    ) u_period_counter (
        .i_clk         (IN_CLK),
        .i_rst         (IN_RST),
        .i_load        (w_load),
        .i_clear       (w_clear),
        .i_run         (w_run),
        .i_period      (ACP_PERIOD),
        .o_terminal_c  (w_terminal),
        .o_pulse_end_c (w_pulse_end)
    );

    // Pulse FSM with registered ACP, RUNNING and azimuth; EN is registered once before use.
    always_ff @(posedge IN_CLK) begin
        if (IN_RST) begin
            r_state   <= IDLE;
            r_en      <= 1'b0;
            r_acp     <= 1'b0;
            r_running <= 1'b0;
            r_az      <= '0;
        end else begin
            r_en <= EN;
            case (r_state)
                IDLE: begin
                    if (r_en) begin
                        r_state   <= HIGH;
                        r_acp     <= 1'b1;
                        r_running <= 1'b1;
                        r_az      <= '0;
                    end
                end
                HIGH: begin
                    if (w_pulse_end) begin
                        r_state <= LOW;
                        r_acp   <= 1'b0;
                    end
                end
                LOW: begin
                    if (w_terminal) begin
                        if (r_en) begin
                            r_state <= HIGH;
                            r_acp   <= 1'b1;
                            r_az    <= w_az_inc;
                        end else begin
                            r_state   <= IDLE;
                            r_running <= 1'b0;
                            r_az      <= '0;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_acp     <= 1'b0;
                    r_running <= 1'b0;
                    r_az      <= '0;
                end
            endcase
        end
    end

`ifdef ACP_ARP_EN
    // ARP follows ACP only for the pulse that lands on azimuth zero.
    always_ff @(posedge IN_CLK) begin
        if (IN_RST) begin
            r_arp <= 1'b0;
        end else if ((r_state == IDLE) && r_en) begin
            r_arp <= 1'b1;
        end else if ((r_state == HIGH) && w_pulse_end) begin
            r_arp <= 1'b0;
        end else if ((r_state == LOW) && w_terminal && r_en) begin
            r_arp <= w_wrap;
        end
    end

    assign RADAR_ARP = r_arp;
`else
    assign RADAR_ARP = 1'b0;
`endif

    assign RADAR_ACP = r_acp;
    assign AZIMUTH   = r_az;
    assign RUNNING   = r_running;

endmodule : acp_arp_generator

// File: tb/tb_acp_arp_generator.sv
// tb_acp_arp_generator: table-driven runs plus hand-written corner sequences;
// expected pulses are queued when stimulus is applied and checked as they appear.
module tb_acp_arp_generator;

    localparam int unsigned ACP_PER_REV  = 8;
    localparam int unsigned PULSE_CYCLES = 4;
    localparam int unsigned PERIOD_W     = 32;
    localparam int unsigned AZ_W         = 3;

`ifdef ACP_ARP_EN
    localparam bit ARP_ON = 1'b1;
`else
    localparam bit ARP_ON = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en  = 1'b0;
    logic [PERIOD_W-1:0] period = 32'd10;
    logic                acp;
    logic                arp;
    logic [AZ_W-1:0]     az;
    logic                running;

    always #5 clk = ~clk;

    acp_arp_generator #(
        .ACP_PER_REV  (ACP_PER_REV),
        .PULSE_CYCLES (PULSE_CYCLES),
        .PERIOD_W     (PERIOD_W)
    ) dut (
        .IN_CLK     (clk),
        .IN_RST     (rst),
        .EN         (en),
        .ACP_PERIOD (period),
        .RADAR_ACP  (acp),
        .RADAR_ARP  (arp),
        .AZIMUTH    (az),
        .RUNNING    (running)
    );

    typedef struct {
        logic [AZ_W-1:0] az;
        int              spacing;
    } exp_t;

    typedef struct {
        logic [PERIOD_W-1:0] period;
        int                  eff;
        int                  n_pulses;
    } vec_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_pulse(input int idx, input int spacing);
        exp_t e;
        e.az      = AZ_W'(idx % ACP_PER_REV);
        e.spacing = spacing;
        sb.push_back(e);
    endtask

    // Pulse monitor: compares each rising edge against the scoreboard head.
    logic prev_acp  = 1'b0;
    int   hi_cnt    = 0;
    int   last_rise = 0;
    bit   have_rise = 1'b0;
    bit   mon_on    = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            if (!running) have_rise = 1'b0;
            check("arp_level", arp, acp & ARP_ON & (az == '0));
            if (acp && !prev_acp) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got pulse at azimuth %0d, expected none (t=%0t)", az, $time);
                end else begin
                    e = sb.pop_front();
                    check("pulse_azimuth", az, e.az);
                    if (e.spacing != 0)
                        check("pulse_spacing", have_rise ? (cyc - last_rise) : -1, e.spacing);
                end
                last_rise = cyc;
                have_rise = 1'b1;
                hi_cnt    = 1;
            end else if (acp) begin
                hi_cnt++;
            end else if (prev_acp && running) begin
                check("pulse_width", hi_cnt, PULSE_CYCLES);
            end
            prev_acp = acp;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Wait (bounded) until the scoreboard holds at most n entries.
    task automatic wait_size(input int n, input int bound);
        int i = 0;
        while (sb.size() > n && i < bound) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("scoreboard_level", sb.size(), n);
        while (sb.size() > n) void'(sb.pop_back());
    endtask

    // Wait (bounded) for the generator to return to idle, then confirm idle outputs.
    task automatic wait_idle(input int bound);
        int i = 0;
        while (running && i < bound) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("stop_running", running, 0);
        check("stop_azimuth", az, 0);
        check("stop_acp", acp, 0);
        repeat (4) @(posedge clk);
        #1;
        check("stop_quiet", acp, 0);
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{32'd10, 10, 9};
        vecs[1] = '{32'd3,   8, 6};
        vecs[2] = '{32'd0,   8, 4};
        vecs[3] = '{32'd8,   8, 3};
        vecs[4] = '{32'd9,   9, 10};
        vecs[5] = '{32'd25, 25, 3};

        // Reset state.
        period = 32'd10;
        do_reset();
        mon_on = 1'b1;
        check("reset_acp", acp, 0);
        check("reset_arp", arp, 0);
        check("reset_azimuth", az, 0);
        check("reset_running", running, 0);

        // Start latency: EN sampled at edge k, outputs high after edge k+1.
        push_pulse(0, 0);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("start_k_acp", acp, 0);
        check("start_k_running", running, 0);
        @(posedge clk);
        #1;
        check("start_k1_acp", acp, 1);
        check("start_k1_running", running, 1);
        check("start_k1_azimuth", az, 0);
        check("start_k1_arp", arp, ARP_ON);
        wait_size(0, 20);
        en = 1'b0;
        wait_idle(40);

        // Table: period/clamp cases, each run then stopped mid-pulse.
        foreach (vecs[v]) begin
            do_reset();
            period = vecs[v].period;
            for (int i = 0; i < vecs[v].n_pulses; i++)
                push_pulse(i, (i == 0) ? 0 : vecs[v].eff);
            en = 1'b1;
            wait_size(0, vecs[v].n_pulses * vecs[v].eff + 40);
            en = 1'b0;
            wait_idle(vecs[v].eff + 20);
        end

        // Period change at azimuth 3: takes effect from the ARP (or only after restart without ARP).
        do_reset();
        period = 32'd10;
        for (int i = 0; i < 11; i++)
            push_pulse(i, (i == 0) ? 0 : ((i >= 9 && ARP_ON) ? 20 : 10));
        en = 1'b1;
        wait_size(7, 100);
        period = 32'd20;
        wait_size(0, 300);
        en = 1'b0;
        wait_idle(40);
        push_pulse(0, 0);
        push_pulse(1, 20);
        en = 1'b1;
        wait_size(0, 80);
        en = 1'b0;
        wait_idle(40);

        // Reset during the pulse at azimuth 2, EN held high through it.
        do_reset();
        period = 32'd10;
        for (int i = 0; i < 3; i++)
            push_pulse(i, (i == 0) ? 0 : 10);
        en = 1'b1;
        wait_size(0, 60);
        check("midreset_pre_acp", acp, 1);
        rst = 1'b1;
        push_pulse(0, 0);
        @(posedge clk);
        #1;
        check("midreset_acp", acp, 0);
        check("midreset_arp", arp, 0);
        check("midreset_azimuth", az, 0);
        check("midreset_running", running, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("restart_wait_acp", acp, 0);
        @(posedge clk);
        #1;
        check("restart_acp", acp, 1);
        check("restart_azimuth", az, 0);
        check("restart_arp", arp, ARP_ON);
        wait_size(0, 20);
        en = 1'b0;
        wait_idle(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_acp_arp_generator

// File: doc/acp_arp_generator.md
# acp_arp_generator

Parametrised successor to the fixed-rate ACP divider: generates the radar Azimuth Change Pulse (ACP) train with a run-time period, plus an Azimuth Reference Pulse (ARP) once per revolution and a live azimuth index. It sits between the 100 MHz fabric clock and the radar-simulator output pins. It also feeds the azimuth index to the target/clutter playback logic so that playback is locked to simulated antenna position.

## Interface
- `ACP_PER_REV`, 4096 — ACP pulses per antenna revolution; must be a power of two, ≥ 2.
- `PULSE_CYCLES`, 50 — high time of each ACP/ARP pulse, in `IN_CLK` cycles; ≥ 1.
- `PERIOD_W`, 32 — width of the period input.
- `AZ_W`, `$clog2(ACP_PER_REV)` — azimuth index width (derived; not overridden).
- `IN_CLK`  in  1 — fabric clock, FREQ_HZ 100000000.
- `IN_RST`  in  1 — synchronous, active-high reset.
- `EN`  in  1 — run request; level-sensitive.
- `ACP_PERIOD`  in  `PERIOD_W` — cycles from one ACP rising edge to the next; 146484 gives 682 Hz.
- `RADAR_ACP`  out  1 — ACP pulse train.
- `RADAR_ARP`  out  1 — revolution reference pulse.
- `AZIMUTH`  out  `AZ_W` — index of the most recent ACP pulse.
- `RUNNING`  out  1 — high while pulses are being generated (states HIGH/LOW).

## Operation
- **States:**
  - IDLE: outputs low, `AZIMUTH` = 0.
  - HIGH: pulse asserted.
  - LOW: gap between pulses.
  - Transitions:
    - IDLE→HIGH when `EN` = 1.
    - HIGH→LOW after `PULSE_CYCLES` cycles in HIGH.
    - LOW→HIGH when the period counter reaches the effective period.
    - LOW→IDLE if `EN` = 0 at the period boundary.
- **Period counter** `cnt`, width `PERIOD_W`, runs 0..P−1. The counter is cleared on every HIGH entry. The next pulse starts when `cnt` = P−1.
- **Effective period P** = max(`ACP_PERIOD`, 2·`PULSE_CYCLES`). This clamps 0 and too-small values; duty cycle is never above 50 %.
- **Period latching:** P is latched on IDLE→HIGH and on every azimuth wrap to 0. A revolution is therefore always uniform. Changes to `ACP_PERIOD` mid-revolution take effect at the next ARP.
- **Azimuth indexing:**
  - `AZIMUTH` is 0 on the first pulse after IDLE.
  - It increments by 1 (mod `ACP_PER_REV`) on each later HIGH entry, and wraps ACP_PER_REV−1→0 with no gap.
- **ARP:** `RADAR_ARP` equals `RADAR_ACP` for the pulse with `AZIMUTH` = 0 and is low otherwise.
- **`EN` deassertion:**
  - Sampled only at the LOW→HIGH boundary. The current pulse and gap always complete, so no runt pulses are produced.
  - On stopping, `AZIMUTH` returns to 0 in IDLE.
- **Re-enable** from IDLE always starts a new revolution at azimuth 0 with ARP.

## Timing
- All outputs are registered.
- **Reset values:** `RADAR_ACP` = 0, `RADAR_ARP` = 0, `AZIMUTH` = 0, `RUNNING` = 0, state IDLE, `cnt` = 0, latched P = 0.
- **Start latency:** `EN` sampled high at edge k → `RADAR_ACP`, `RADAR_ARP` and `RUNNING` are high after edge k+1. `AZIMUTH` = 0.
- **Pulse shape:** pulse width is exactly `PULSE_CYCLES` cycles. Rising edges are exactly P cycles apart.
- **`AZIMUTH` update:** changes on the same edge that raises `RADAR_ACP`.
- **`RUNNING`:** drops on the edge where the state enters IDLE.
- **Mid-operation reset:** `IN_RST` high mid-pulse forces all reset values on the next edge. Reset has priority over `EN`.

## Configuration
- **`ACP_ARP_EN` defined:** ARP logic is compiled in, as described above.
- **`ACP_ARP_EN` undefined:**
  - `RADAR_ARP` is tied to 0.
  - Period latching occurs only on IDLE→HIGH, so `ACP_PERIOD` changes apply only after a stop/start.
  - `AZIMUTH` still counts and wraps.

## Structure
- **Package `acp_pkg`:**
  - state enum `acp_state_t` {IDLE, HIGH, LOW};
  - `ACP_DEFAULT_CLK_HZ` = 100000000;
  - `ACP_DEFAULT_PERIOD` = 146484.
- **Sub-module `acp_period_counter`:** loadable period register plus cycle counter, with `load`, `clear` and `terminal` (cnt = P−1) and `pulse_end` (cnt = PULSE_CYCLES−1) outputs. The top level holds the FSM and the azimuth counter.

## Test plan
- **Reset then start:** `ACP_PER_REV`=8, `PULSE_CYCLES`=4, `ACP_PERIOD`=10, `EN` 0→1.
  - ACP high 4 cycles, rising every 10 cycles.
  - `AZIMUTH` 0,1,…,7,0.
  - ARP high on pulses 0 and 8 only.
- **Clamping:**
  - `ACP_PERIOD`=3 with `PULSE_CYCLES`=4 → period 8 cycles, 4 high / 4 low.
  - `ACP_PERIOD`=0 → same result.
- **Period change:** `ACP_PERIOD` 10→20 at azimuth 3 → pulses 4–7 stay 10 apart; spacing becomes 20 from the ARP onward.
- **Stop:** `EN`→0 mid-HIGH at azimuth 5 → pulse completes, gap completes, IDLE. No pulse 6. `AZIMUTH`=0 and `RUNNING`=0.
- **Reset mid-pulse:** `IN_RST` pulsed during HIGH at azimuth 2 → all outputs 0 next edge. With `EN` still 1, restart one cycle after reset release at azimuth 0 with ARP.
- **Macro off:** build without `ACP_ARP_EN` → `RADAR_ARP` constantly 0, and an `ACP_PERIOD` change is ignored until `EN` is toggled.
